// File: rtl/change_pkg.sv
// ============================================================================
// Module      : change_pkg
// Description : Shared types and constants for the change dispenser.
//               - state_t    : dispenser FSM states
//               - DEN_*      : coin denominations
//               - coin_sel_t : one-hot coin select (bit 4 = 100 ... bit 0 = 1)
//               - pick_coin  : largest denomination not exceeding an amount
//               - coin_value : face value of a one-hot coin select
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package change_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SELECT = 3'd1,
      PULSE  = 3'd2,
      GAP    = 3'd3,
      DONE   = 3'd4
   } state_t;

   localparam int unsigned DEN_100 = 100;
   localparam int unsigned DEN_50  = 50;
   localparam int unsigned DEN_10  = 10;
   localparam int unsigned DEN_5   = 5;
   localparam int unsigned DEN_1   = 1;

   // Bit positions match the output lines {co100,co50,co10,co5,co1}.
   typedef enum logic [4:0] {
      COIN_NONE = 5'b00000,
      COIN_1    = 5'b00001,
      COIN_5    = 5'b00010,
      COIN_10   = 5'b00100,
      COIN_50   = 5'b01000,
      COIN_100  = 5'b10000
   } coin_sel_t;

   // Greedy choice; optimal for this coin set.
   function automatic coin_sel_t pick_coin(input logic [31:0] rem);
      if (rem >= DEN_100)     return COIN_100;
      else if (rem >= DEN_50) return COIN_50;
      else if (rem >= DEN_10) return COIN_10;
      else if (rem >= DEN_5)  return COIN_5;
      else if (rem >= DEN_1)  return COIN_1;
      else                    return COIN_NONE;
   endfunction

   function automatic int unsigned coin_value(input coin_sel_t sel);
      case (sel)
         COIN_100: return DEN_100;
         COIN_50:  return DEN_50;
         COIN_10:  return DEN_10;
         COIN_5:   return DEN_5;
         COIN_1:   return DEN_1;
         default:  return 0;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/pulse_timer.sv
// ============================================================================
// Module      : pulse_timer
// Description : Loadable down-counter timing the PULSE and GAP phases.
//               Loading value N-1 gives an N-cycle phase: expire is high on
//               the last cycle of the phase (counter at zero).
// Ports       : clk      - rising-edge clock
//               rst      - asynchronous active-high reset
//               load     - load load_val into the counter
//               load_val - phase length minus one
//               expire   - counter is zero (last cycle of the phase)
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pulse_timer #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             expire
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (load) begin
         r_cnt <= load_val;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   assign expire = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/change_dispenser.sv
// ============================================================================
// Module      : change_dispenser
// Description : Emits coin-eject pulses for a change amount, largest
//               denomination first (100/50/10/5/1). Each coin occupies one
//               SELECT cycle, PULSE_W high cycles and GAP_W low cycles.
// Ports       : clk, rst       - clock, asynchronous active-high reset
//               start, amount  - request and amount, sampled in IDLE only
//               busy           - transaction in progress (SELECT/PULSE/GAP)
//               done           - one-cycle completion pulse
//               remaining      - amount still to be dispensed
//               co100..co1     - registered coin-eject pulses, one-hot
//               n100..n1       - per-denomination coin counts (optional)
// Config      : CHANGE_TALLY_EN - when defined, adds the n100..n1 tally
//               outputs, cleared on accepted start, bumped on the last
//               PULSE cycle of each coin.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module change_dispenser
   import change_pkg::*;
#(
   parameter int AMT_W   = 8,
   parameter int PULSE_W = 4,
   parameter int GAP_W   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [AMT_W-1:0] amount,
   output logic             busy,
   output logic             done,
   output logic [AMT_W-1:0] remaining,
   output logic             co100,
   output logic             co50,
   output logic             co10,
   output logic             co5,
   output logic             co1
`ifdef CHANGE_TALLY_EN
   ,
   output logic [3:0]       n100,
   output logic [3:0]       n50,
   output logic [3:0]       n10,
   output logic [3:0]       n5,
   output logic [3:0]       n1
`endif
);

   // Timer only has to hold the longer phase length minus one.
   localparam int c_TMR_MAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
   localparam int c_TMR_W   = (c_TMR_MAX > 1) ? $clog2(c_TMR_MAX) : 1;
   localparam logic [c_TMR_W-1:0] c_PULSE_LD = c_TMR_W'(PULSE_W - 1);
   localparam logic [c_TMR_W-1:0] c_GAP_LD   = c_TMR_W'(GAP_W - 1);

   state_t             r_state;
   coin_sel_t          r_sel;
   logic [4:0]         r_co;
   coin_sel_t          w_pick;
   logic [AMT_W-1:0]   w_dec;
   logic               w_tmr_load;
   logic [c_TMR_W-1:0] w_tmr_val;
   logic               w_tmr_expire;

   assign w_pick = pick_coin(32'(remaining));
   assign w_dec  = AMT_W'(coin_value(r_sel));

   assign co100 = r_co[4];
   assign co50  = r_co[3];
   assign co10  = r_co[2];
   assign co5   = r_co[1];
   assign co1   = r_co[0];

   // The timer is loaded on entry to each timed phase: from SELECT for the
   // pulse, and on the last pulse cycle for the gap.
   always_comb begin
      w_tmr_load = 1'b0;
      w_tmr_val  = c_PULSE_LD;
      case (r_state)
         SELECT: begin
            if (remaining != '0) begin
               w_tmr_load = 1'b1;
               w_tmr_val  = c_PULSE_LD;
            end
         end
         PULSE: begin
            if (w_tmr_expire) begin
               w_tmr_load = 1'b1;
               w_tmr_val  = c_GAP_LD;
            end
         end
         default: begin
            w_tmr_load = 1'b0;
         end
      endcase
   end

   pulse_timer #(
      .CNT_W (c_TMR_W)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (w_tmr_load),
      .load_val (w_tmr_val),
      .expire   (w_tmr_expire)
   );

`ifdef CHANGE_TALLY_EN
   logic [3:0] r_n100, r_n50, r_n10, r_n5, r_n1;
   assign n100 = r_n100;
   assign n50  = r_n50;
   assign n10  = r_n10;
   assign n5   = r_n5;
   assign n1   = r_n1;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_sel     <= COIN_NONE;
         r_co      <= 5'b00000;
         busy      <= 1'b0;
         done      <= 1'b0;
         remaining <= '0;
`ifdef CHANGE_TALLY_EN
         r_n100    <= 4'd0;
         r_n50     <= 4'd0;
         r_n10     <= 4'd0;
         r_n5      <= 4'd0;
         r_n1      <= 4'd0;
`endif
      end else begin
         done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  remaining <= amount;
                  busy      <= 1'b1;
                  r_state   <= SELECT;
`ifdef CHANGE_TALLY_EN
                  r_n100    <= 4'd0;
                  r_n50     <= 4'd0;
                  r_n10     <= 4'd0;
                  r_n5      <= 4'd0;
                  r_n1      <= 4'd0;
`endif
               end
            end
            SELECT: begin
               if (remaining == '0) begin
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  r_state <= DONE;
               end else begin
                  r_sel   <= w_pick;
                  r_co    <= w_pick;
                  r_state <= PULSE;
               end
            end
            PULSE: begin
               if (w_tmr_expire) begin
                  // w_dec never exceeds remaining: the coin was picked from it.
                  remaining <= remaining - w_dec;
                  r_co      <= 5'b00000;
                  r_state   <= GAP;
`ifdef CHANGE_TALLY_EN
                  case (r_sel)
                     COIN_100: r_n100 <= r_n100 + 4'd1;
                     COIN_50:  r_n50  <= r_n50  + 4'd1;
                     COIN_10:  r_n10  <= r_n10  + 4'd1;
                     COIN_5:   r_n5   <= r_n5   + 4'd1;
                     COIN_1:   r_n1   <= r_n1   + 4'd1;
                     default:  r_n1   <= r_n1;
                  endcase
`endif
               end
            end
            GAP: begin
               if (w_tmr_expire) begin
                  r_state <= SELECT;
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_co    <= 5'b00000;
               busy    <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_change_dispenser.sv
// ============================================================================
// Module      : tb_change_dispenser
// Description : Self-checking bench for change_dispenser. Expected coin
//               sequences come from a greedy arithmetic model; the co* lines
//               are recounted like the downstream coin counter would.
//               Tally outputs are checked when CHANGE_TALLY_EN is defined.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_change_dispenser;

   localparam int P = 3;
   localparam int G = 2;
   localparam int N = 1 + P + G;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] amount;
   logic       busy;
   logic       done;
   logic [7:0] remaining;
   logic       co100, co50, co10, co5, co1;
`ifdef CHANGE_TALLY_EN
   logic [3:0] n100, n50, n10, n5, n1;
`endif

   change_dispenser #(
      .AMT_W   (8),
      .PULSE_W (P),
      .GAP_W   (G)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .amount    (amount),
      .busy      (busy),
      .done      (done),
      .remaining (remaining),
      .co100     (co100),
      .co50      (co50),
      .co10      (co10),
      .co5       (co5),
      .co1       (co1)
`ifdef CHANGE_TALLY_EN
      ,
      .n100      (n100),
      .n50       (n50),
      .n10       (n10),
      .n5        (n5),
      .n1        (n1)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int exp_q[$];

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Greedy change in plain arithmetic.
   task automatic build_exp(input int amt);
      int dens[5];
      int r;
      dens = '{100, 50, 10, 5, 1};
      exp_q.delete();
      r = amt;
      for (int i = 0; i < 5; i++) begin
         while (r >= dens[i]) begin
            exp_q.push_back(dens[i]);
            r -= dens[i];
         end
      end
   endtask

   function automatic int den_of(input logic [4:0] v);
      case (v)
         5'b10000: return 100;
         5'b01000: return 50;
         5'b00100: return 10;
         5'b00010: return 5;
         5'b00001: return 1;
         default:  return 0;
      endcase
   endfunction

   function automatic int count_of(input int d);
      int c = 0;
      foreach (exp_q[i]) if (exp_q[i] == d) c++;
      return c;
   endfunction

   // One transaction. hold=1 keeps start high and scrambles amount while busy.
   // exp_edges: clock edges expected from raising start to acceptance.
   task automatic run_txn(input int amt, input bit hold, input int exp_edges);
      int edges, k, done_k, w, lowrun, sum, exp_rem;
      int bad_w, bad_gap, multi, rem_bad, busy_bad, seq_bad;
      int got_q[$];
      logic [4:0] prev, cur;
      bit seen;
      build_exp(amt);
      start  = 1'b1;
      amount = 8'(amt);
      edges  = 0;
      seen   = 1'b0;
      while (!seen && edges < 4) begin
         @(posedge clk); #1;
         edges++;
         if (busy) seen = 1'b1;
      end
      check("accept_edges", edges, exp_edges);
      if (!hold) start = 1'b0;
      check("rem_captured", int'(remaining), amt);
      k = 0; done_k = -1; w = 0; lowrun = 0; sum = 0; exp_rem = amt;
      bad_w = 0; bad_gap = 0; multi = 0; rem_bad = 0; busy_bad = 0; seq_bad = 0;
      prev = {co100, co50, co10, co5, co1};
      while (done_k < 0 && k < 12 * N + 10) begin
         if (hold) amount = 8'($urandom_range(0, 255));
         @(posedge clk); #1;
         k++;
         cur = {co100, co50, co10, co5, co1};
         if ($countones(cur) > 1) multi++;
         if (cur != 5'b0 && prev == 5'b0) begin
            if (got_q.size() > 0 && lowrun != G + 1) bad_gap++;
            got_q.push_back(den_of(cur));
            w = 1;
         end else if (cur != 5'b0 && cur == prev) begin
            w++;
         end else if (cur != 5'b0) begin
            bad_gap++;
         end
         if (cur == 5'b0 && prev != 5'b0) begin
            if (w != P) bad_w++;
            exp_rem -= den_of(prev);
            sum     += den_of(prev);
            if (int'(remaining) != exp_rem) rem_bad++;
            lowrun = 1;
         end else if (cur == 5'b0) begin
            lowrun++;
         end
         if (done) begin
            done_k = k;
            if (busy) busy_bad++;
         end else if (!busy) begin
            busy_bad++;
         end
         prev = cur;
      end
      if (hold) start = 1'b0;
      if (got_q.size() != exp_q.size()) seq_bad = 1;
      else foreach (exp_q[i]) if (got_q[i] != exp_q[i]) seq_bad++;
      check("done_cycle", done_k, exp_q.size() * N + 1);
      check("coin_count", got_q.size(), exp_q.size());
      check("coin_seq_bad", seq_bad, 0);
      check("pulse_width_bad", bad_w, 0);
      check("gap_bad", bad_gap, 0);
      check("multi_high", multi, 0);
      check("remaining_step_bad", rem_bad, 0);
      check("busy_bad", busy_bad, 0);
      check("loopback_total", sum, amt);
      check("remaining_end", int'(remaining), 0);
`ifdef CHANGE_TALLY_EN
      check("n100", int'(n100), count_of(100));
      check("n50", int'(n50), count_of(50));
      check("n10", int'(n10), count_of(10));
      check("n5", int'(n5), count_of(5));
      check("n1", int'(n1), count_of(1));
`endif
   endtask

   function automatic int outs_or();
      return int'({busy, done, remaining, co100, co50, co10, co5, co1});
   endfunction

   initial begin
      rst    = 1'b1;
      start  = 1'b0;
      amount = 8'd0;
      #1;
      check("reset_outputs", outs_or(), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Directed cases.
      run_txn(186, 1'b0, 1);
      repeat (2) @(posedge clk); #1;
      run_txn(0, 1'b0, 1);
      repeat (2) @(posedge clk); #1;
      run_txn(255, 1'b0, 1);
      repeat (2) @(posedge clk); #1;
      run_txn(1, 1'b1, 1);
      repeat (2) @(posedge clk); #1;
      run_txn(99, 1'b1, 1);
      // Back-to-back: start raised in DONE, accepted in the following IDLE.
      run_txn(186, 1'b0, 2);
      run_txn(37, 1'b0, 2);

      // Reset in the middle of a pulse.
      repeat (2) @(posedge clk); #1;
      start  = 1'b1;
      amount = 8'd186;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check("midrun_pulse_active", int'(co100), 1);
      rst = 1'b1;
      #1;
      check("midrun_reset_outputs", outs_or(), 0);
      repeat (2) begin
         @(posedge clk); #1;
         check("midrun_no_done", int'(done), 0);
      end
      @(negedge clk);
      rst = 1'b0;
      run_txn(5, 1'b0, 1);

      // Randomised amounts and hold modes.
      for (int t = 0; t < 20; t++) begin
         repeat ($urandom_range(1, 3)) @(posedge clk);
         #1;
         run_txn(int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
